// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle control FSM for the RV32I-subset core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared memory port
// with a ready handshake, traps on illegal opcodes or memory timeouts and
// counts retired instructions.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   opcode_i, funct3_i    instruction fields from the IR
//   zero_i                ALU zero flag (branch compare)
//   mem_ready_i           memory completes the current request this cycle
//   mem_req_o/we_o/sel_o  memory request, write enable, address mux (1 = ALU)
//   ir_write_o            load IR, mdr_write_o load MDR
//   pc_write_o/pc_src_o   PC update and source (1 = branch target)
//   alu_src_o/alu_op_o    ALU operand B select and operation class
//   reg_write_o           register write, mem_to_reg_o writeback source
//   state_o               current state encoding
//   trap_o/trap_cause_o   sticky trap flag and cause (01 illegal, 10 timeout)
//   instr_count_o         retired instruction counter
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [6:0]         opcode_i,
    input  logic [2:0]         funct3_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               mem_sel_o,
    output logic               ir_write_o,
    output logic               mdr_write_o,
    output logic               pc_write_o,
    output logic               pc_src_o,
    output logic               alu_src_o,
    output logic [1:0]         alu_op_o,
    output logic               reg_write_o,
    output logic               mem_to_reg_o,
    output logic [2:0]         state_o,
    output logic               trap_o,
    output logic [1:0]         trap_cause_o,
    output logic [COUNT_W-1:0] instr_count_o
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd7
    } state_t;

    typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BEQ, C_BNE} class_t;

    state_t            state, state_n;
    class_t            cls, cls_dec;
    logic [1:0]        cause_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out, is_branch, taken, alu_src_c;
    logic [1:0]        alu_op_c;

    always_comb begin
        cls_dec = opcode_i == 7'b0110011 ? C_R :
                  opcode_i == 7'b0010011 ? C_I :
                  opcode_i == 7'b0000011 ? C_LOAD :
                  opcode_i == 7'b0100011 ? C_STORE :
                  (opcode_i == 7'b1100011 && funct3_i == 3'b000) ? C_BEQ :
                  (opcode_i == 7'b1100011 && funct3_i == 3'b001) ? C_BNE : C_NONE;
    end

    // The last tolerated request cycle is the one where wait_cnt == TIMEOUT-1.
    assign timed_out = !mem_ready_i && wait_cnt == WAIT_W'(TIMEOUT - 1);
    assign is_branch = cls == C_BEQ || cls == C_BNE;
    assign taken     = cls == C_BEQ ? zero_i : !zero_i;
    assign alu_src_c = cls == C_I || cls == C_LOAD || cls == C_STORE;
    assign alu_op_c  = (cls == C_R || cls == C_I) ? 2'b10 : is_branch ? 2'b01 : 2'b00;
    assign state_o   = state;
    assign trap_o    = state == TRAP;

    always_comb begin
        state_n = state;
        cause_n = trap_cause_o;
        case (state)
            FETCH:     state_n = mem_ready_i ? DECODE : timed_out ? TRAP : FETCH;
            DECODE:    state_n = cls_dec == C_NONE ? TRAP : EXECUTE;
            EXECUTE:   state_n = (cls == C_R || cls == C_I) ? WRITEBACK :
                                 (cls == C_LOAD || cls == C_STORE) ? MEM :
                                 is_branch ? FETCH : TRAP;
            MEM:       state_n = mem_ready_i ? (cls == C_STORE ? FETCH : WRITEBACK) :
                                 timed_out ? TRAP : MEM;
            WRITEBACK: state_n = FETCH;
            TRAP:      state_n = TRAP;
            default:   state_n = TRAP;
        endcase
        if (state_n == TRAP && state != TRAP)
            cause_n = (timed_out && (state == FETCH || state == MEM)) ? 2'b10 : 2'b01;
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_sel_o    = 1'b0;
        ir_write_o   = 1'b0;
        mdr_write_o  = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = 2'b00;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req_o  = 1'b1;
                    ir_write_o = mem_ready_i;
                end
                EXECUTE: begin
                    alu_src_o  = alu_src_c;
                    alu_op_o   = alu_op_c;
                    pc_write_o = is_branch;
                    pc_src_o   = is_branch && taken;
                end
                MEM: begin
                    // ALU controls held so the address stays stable across waits
                    mem_req_o   = 1'b1;
                    mem_sel_o   = 1'b1;
                    mem_we_o    = cls == C_STORE;
                    alu_src_o   = alu_src_c;
                    alu_op_o    = alu_op_c;
                    pc_write_o  = mem_ready_i && cls == C_STORE;
                    mdr_write_o = mem_ready_i && cls == C_LOAD;
                end
                WRITEBACK: begin
                    alu_src_o    = alu_src_c;
                    alu_op_o     = alu_op_c;
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = cls == C_LOAD;
                    pc_write_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every retirement produces exactly one pc_write pulse, so it drives the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= FETCH;
            cls           <= C_NONE;
            trap_cause_o  <= 2'b00;
            instr_count_o <= '0;
            wait_cnt      <= '0;
        end else begin
            state         <= state_n;
            trap_cause_o  <= cause_n;
            instr_count_o <= instr_count_o + COUNT_W'(pc_write_o);
            wait_cnt      <= (mem_req_o && !mem_ready_i) ? wait_cnt + 1'b1 : '0;
            if (state == DECODE) cls <= cls_dec;
        end
    end
endmodule
